// File: rtl/lc3b_types.sv
// Shared LC-3b types: opcodes, the decoded instruction packet and the memory-stage FSM states.
package lc3b_types;

  localparam int unsigned LC3B_ADDR_W = 16;
  localparam int unsigned LC3B_DATA_W = 16;

  typedef logic [LC3B_DATA_W-1:0] lc3b_word;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LDB  = 4'h2,
    OP_STB  = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_RTI  = 4'h8,
    OP_NOT  = 4'h9,
    OP_LDI  = 4'hA,
    OP_STI  = 4'hB,
    OP_JMP  = 4'hC,
    OP_SHF  = 4'hD,
    OP_LEA  = 4'hE,
    OP_TRAP = 4'hF
  } lc3b_opcode;

  typedef struct packed {
    lc3b_opcode opcode;
    logic [2:0] dr;
    logic       ld_reg;
    logic       ld_cc;
    lc3b_word   pc;
  } lc3b_ipacket;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PTR  = 2'd1,
    S_ACC  = 2'd2
  } lc3b_mem_state_t;

  function automatic logic is_mem_op(input lc3b_opcode op);
    return op inside {OP_LDB, OP_STB, OP_LDR, OP_STR, OP_LDI, OP_STI};
  endfunction

  function automatic logic is_indirect(input lc3b_opcode op);
    return op inside {OP_LDI, OP_STI};
  endfunction

  function automatic logic is_store(input lc3b_opcode op);
    return op inside {OP_STB, OP_STR, OP_STI};
  endfunction

  function automatic logic is_byte_op(input lc3b_opcode op);
    return op inside {OP_LDB, OP_STB};
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for data-memory accesses: address alignment, lane enables,
// store data replication and sign-extended byte loads.
module mem_align
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_W = LC3B_ADDR_W,
  parameter int unsigned DATA_W = LC3B_DATA_W
) (
  input  lc3b_opcode        opcode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] sr_data,
  input  logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] aligned_addr_c,
  output logic [1:0]        byte_en_c,
  output logic [DATA_W-1:0] wdata_c,
  output logic [DATA_W-1:0] load_data_c
);

  logic [7:0] sel_byte;

  always_comb begin
    aligned_addr_c = addr;
    byte_en_c      = 2'b11;
    wdata_c        = sr_data;
    load_data_c    = rdata;
    sel_byte       = addr[0] ? rdata[15:8] : rdata[7:0];
    if (is_byte_op(opcode)) begin
      byte_en_c   = addr[0] ? 2'b10 : 2'b01;
      wdata_c     = {sr_data[7:0], sr_data[7:0]};
      load_data_c = {{(DATA_W-8){sel_byte[7]}}, sel_byte};
    end else begin
      aligned_addr_c[0] = 1'b0;
    end
  end

endmodule

// File: rtl/mem_access.sv
// LC-3b memory stage: pass-through for non-memory ops, request/response data-memory
// accesses (with LDI/STI pointer indirection) and the writeback packet register.
module mem_access
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_W = LC3B_ADDR_W,
  parameter int unsigned DATA_W = LC3B_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  lc3b_ipacket       in_ipacket,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] sr_in,
  input  logic [DATA_W-1:0] br_addr_in,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        mem_byte_enable,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              stall,
  output logic              wb_valid,
  output lc3b_ipacket       wb_ipacket,
  output logic [DATA_W-1:0] wb_alu,
  output logic [DATA_W-1:0] wb_mem,
  output logic [DATA_W-1:0] wb_br_addr
);

  lc3b_mem_state_t   state_q, state_d;
  logic              kill_q, kill_d;
  lc3b_ipacket       pkt_q, pkt_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] br_q, br_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              wb_valid_q, wb_valid_d;
  lc3b_ipacket       wb_ipacket_q, wb_ipacket_d;
  logic [DATA_W-1:0] wb_alu_q, wb_alu_d;
  logic [DATA_W-1:0] wb_mem_q, wb_mem_d;
  logic [DATA_W-1:0] wb_br_q, wb_br_d;

  logic              issue_c;
  logic              kill_now_c;
  lc3b_opcode        al_op_c;
  logic [ADDR_W-1:0] al_addr_c;
  logic [DATA_W-1:0] al_sr_c;
  logic [ADDR_W-1:0] aligned_addr_c;
  logic [1:0]        byte_en_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] load_data_c;

  assign issue_c    = (state_q == S_IDLE) && in_valid && !flush && is_mem_op(in_ipacket.opcode);
  assign kill_now_c = kill_q | flush;

  // Issue cycle steers from the live inputs; afterwards only the latched copies are used.
  always_comb begin
    al_op_c   = pkt_q.opcode;
    al_addr_c = addr_q;
    al_sr_c   = sr_q;
    if (state_q == S_IDLE) begin
      al_op_c   = in_ipacket.opcode;
      al_addr_c = ADDR_W'(alu_in);
      al_sr_c   = sr_in;
    end
  end

  mem_align #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_align (
    .opcode         (al_op_c),
    .addr           (al_addr_c),
    .sr_data        (al_sr_c),
    .rdata          (mem_rdata),
    .aligned_addr_c (aligned_addr_c),
    .byte_en_c      (byte_en_c),
    .wdata_c        (wdata_c),
    .load_data_c    (load_data_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      kill_q       <= 1'b0;
      pkt_q        <= '0;
      sr_q         <= '0;
      alu_q        <= '0;
      br_q         <= '0;
      addr_q       <= '0;
      wb_valid_q   <= 1'b0;
      wb_ipacket_q <= '0;
      wb_alu_q     <= '0;
      wb_mem_q     <= '0;
      wb_br_q      <= '0;
    end else begin
      state_q      <= state_d;
      kill_q       <= kill_d;
      pkt_q        <= pkt_d;
      sr_q         <= sr_d;
      alu_q        <= alu_d;
      br_q         <= br_d;
      addr_q       <= addr_d;
      wb_valid_q   <= wb_valid_d;
      wb_ipacket_q <= wb_ipacket_d;
      wb_alu_q     <= wb_alu_d;
      wb_mem_q     <= wb_mem_d;
      wb_br_q      <= wb_br_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    kill_d          = kill_q;
    pkt_d           = pkt_q;
    sr_d            = sr_q;
    alu_d           = alu_q;
    br_d            = br_q;
    addr_d          = addr_q;
    wb_valid_d      = 1'b0;
    wb_ipacket_d    = wb_ipacket_q;
    wb_alu_d        = wb_alu_q;
    wb_mem_d        = wb_mem_q;
    wb_br_d         = wb_br_q;
    mem_address     = aligned_addr_c;
    mem_wdata       = wdata_c;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 2'b00;
    stall           = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        kill_d       = 1'b0;
        wb_valid_d   = in_valid && !flush && !is_mem_op(in_ipacket.opcode);
        wb_ipacket_d = in_ipacket;
        wb_alu_d     = alu_in;
        wb_br_d      = br_addr_in;
        wb_mem_d     = '0;
        if (issue_c) begin
          stall           = 1'b1;
          mem_byte_enable = byte_en_c;
          // Indirect ops always start with the pointer read, even STI.
          if (is_indirect(in_ipacket.opcode) || !is_store(in_ipacket.opcode)) begin
            mem_read = 1'b1;
          end else begin
            mem_write = 1'b1;
          end
          pkt_d   = in_ipacket;
          sr_d    = sr_in;
          alu_d   = alu_in;
          br_d    = br_addr_in;
          addr_d  = ADDR_W'(alu_in);
          state_d = is_indirect(in_ipacket.opcode) ? S_PTR : S_ACC;
        end
      end

      S_PTR: begin
        mem_read        = 1'b1;
        mem_byte_enable = byte_en_c;
        stall           = !(mem_resp && kill_now_c);
        kill_d          = kill_now_c;
        if (mem_resp) begin
          addr_d = ADDR_W'(mem_rdata);
          if (kill_now_c) begin
            kill_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_ACC;
          end
        end
      end

      S_ACC: begin
        mem_byte_enable = byte_en_c;
        mem_write       = is_store(pkt_q.opcode);
        mem_read        = !is_store(pkt_q.opcode);
        // Releasing stall on the response lets upstream advance exactly once.
        stall           = !mem_resp;
        kill_d          = kill_now_c;
        if (mem_resp) begin
          wb_valid_d   = !kill_now_c;
          wb_ipacket_d = pkt_q;
          wb_alu_d     = alu_q;
          wb_br_d      = br_q;
          wb_mem_d     = is_store(pkt_q.opcode) ? '0 : load_data_c;
          kill_d       = 1'b0;
          state_d      = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign wb_valid   = wb_valid_q;
  assign wb_ipacket = wb_ipacket_q;
  assign wb_alu     = wb_alu_q;
  assign wb_mem     = wb_mem_q;
  assign wb_br_addr = wb_br_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed cases plus random ops against a word-memory reference model.
module tb_mem_access;
  import lc3b_types::*;

  localparam int PK_W = $bits(lc3b_ipacket);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  lc3b_ipacket in_ipacket;
  logic [15:0] alu_in, sr_in, br_addr_in;
  logic        flush;
  logic [15:0] mem_address, mem_wdata;
  logic        mem_read, mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        stall;
  logic        wb_valid;
  lc3b_ipacket wb_ipacket;
  logic [15:0] wb_alu, wb_mem, wb_br_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_cnt;
  logic [15:0] mem_model [logic [15:0]];

  mem_access dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ipacket      (in_ipacket),
    .alu_in          (alu_in),
    .sr_in           (sr_in),
    .br_addr_in      (br_addr_in),
    .flush           (flush),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .stall           (stall),
    .wb_valid        (wb_valid),
    .wb_ipacket      (wb_ipacket),
    .wb_alu          (wb_alu),
    .wb_mem          (wb_mem),
    .wb_br_addr      (wb_br_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference rules, written directly from the addressing/lane definitions.
  function automatic bit ref_is_mem(input lc3b_opcode op);
    return op == OP_LDR || op == OP_LDB || op == OP_LDI || op == OP_STR || op == OP_STB || op == OP_STI;
  endfunction

  function automatic bit ref_is_store(input lc3b_opcode op);
    return op == OP_STR || op == OP_STB || op == OP_STI;
  endfunction

  function automatic bit ref_is_word(input lc3b_opcode op);
    return op == OP_LDR || op == OP_LDI || op == OP_STR || op == OP_STI;
  endfunction

  function automatic logic [15:0] ref_addr(input lc3b_opcode op, input logic [15:0] a);
    return ref_is_word(op) ? (a & 16'hFFFE) : a;
  endfunction

  function automatic logic [1:0] ref_be(input lc3b_opcode op, input logic [15:0] a);
    if (ref_is_word(op)) return 2'b11;
    return (a % 2 == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [15:0] ref_wdata(input lc3b_opcode op, input logic [15:0] sr);
    return (op == OP_STB) ? (sr & 16'h00FF) * 16'h0101 : sr;
  endfunction

  function automatic logic [15:0] ref_load(input lc3b_opcode op, input logic [15:0] a,
                                           input logic [15:0] w);
    logic [15:0] b;
    if (op != OP_LDB) return w;
    b = (a % 2 == 1) ? (w >> 8) : (w & 16'h00FF);
    if (b >= 16'h0080) b = b + 16'hFF00;
    return b;
  endfunction

  function automatic logic [15:0] rd(input logic [15:0] a);
    return mem_model.exists(a) ? mem_model[a] : (16'hA5A5 ^ a);
  endfunction

  task automatic model_store(input lc3b_opcode op, input logic [15:0] a, input logic [15:0] sr);
    logic [15:0] wa, w;
    wa = a & 16'hFFFE;
    w  = rd(wa);
    if (op == OP_STB) begin
      if (a % 2 == 1) w = (w & 16'h00FF) + ((sr & 16'h00FF) << 8);
      else            w = (w & 16'hFF00) + (sr & 16'h00FF);
    end else begin
      w = sr;
    end
    mem_model[wa] = w;
  endtask

  task automatic garbage_inputs();
    logic [PK_W-1:0] t;
    t          = PK_W'($urandom);
    in_valid   = 1'b1;
    in_ipacket = lc3b_ipacket'(t);
    alu_in     = 16'($urandom);
    sr_in      = 16'($urandom);
    br_addr_in = 16'($urandom);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    flush    = 1'b0;
    mem_resp = 1'b0;
  endtask

  task automatic chk_req(input string tag, input bit st, input logic [15:0] ea,
                         input logic [1:0] be, input logic [15:0] wd);
    check({tag, "_rd"}, 32'(mem_read), 32'(!st));
    check({tag, "_wr"}, 32'(mem_write), 32'(st));
    check({tag, "_addr"}, 32'(mem_address), 32'(ea));
    check({tag, "_be"}, 32'(mem_byte_enable), 32'(be));
    if (st) check({tag, "_wdata"}, 32'(mem_wdata), 32'(wd));
  endtask

  // fmode: 0 none, 1 flush at issue, 2 flush in first access, 3 flush in last access.
  task automatic run_op(input lc3b_opcode op, input logic [15:0] alu, input logic [15:0] sr,
                        input logic [15:0] br, input int fmode, input int w1, input int w2);
    lc3b_ipacket pk;
    logic [15:0] ea, base, word, ptr, exp_ld;
    logic [1:0]  be;
    bit          ind, st, killed, last, exp_v;
    int          nacc, wt, fk;
    pk.opcode = op;
    pk.dr     = 3'($urandom);
    pk.ld_reg = 1'($urandom);
    pk.ld_cc  = 1'($urandom);
    pk.pc     = 16'($urandom);
    stall_cnt = 0;
    exp_ld    = 16'h0;
    ptr       = 16'h0;
    word      = 16'h0;
    @(negedge clk);
    in_valid   = 1'b1;
    in_ipacket = pk;
    alu_in     = alu;
    sr_in      = sr;
    br_addr_in = br;
    flush      = (fmode == 1);
    mem_resp   = 1'b0;
    mem_rdata  = 16'($urandom);
    #1;
    if (!ref_is_mem(op) || fmode == 1) begin
      check("noreq_rd", 32'(mem_read), 32'(0));
      check("noreq_wr", 32'(mem_write), 32'(0));
      check("noreq_stall", 32'(stall), 32'(0));
      @(negedge clk);
      idle_inputs();
      exp_v = !ref_is_mem(op) && fmode != 1;
      check("pt_valid", 32'(wb_valid), 32'(exp_v));
      if (exp_v) begin
        check("pt_ipacket", 32'(wb_ipacket), 32'(pk));
        check("pt_alu", 32'(wb_alu), 32'(alu));
        check("pt_br", 32'(wb_br_addr), 32'(br));
        check("pt_mem", 32'(wb_mem), 32'(0));
      end
      return;
    end
    ind    = (op == OP_LDI || op == OP_STI);
    nacc   = ind ? 2 : 1;
    fk     = (fmode == 2) ? 0 : ((fmode == 3) ? nacc - 1 : -1);
    killed = 1'b0;
    chk_req("issue", ind ? 1'b0 : ref_is_store(op), ind ? (alu & 16'hFFFE) : ref_addr(op, alu),
            ind ? 2'b11 : ref_be(op, alu), ref_wdata(op, sr));
    check("issue_stall", 32'(stall), 32'(1));
    if (stall) stall_cnt++;
    for (int k = 0; k < nacc; k++) begin
      wt = (k == 0) ? w1 : w2;
      if (fk == k && wt < 1) wt = 1;
      st   = (ind && k == 0) ? 1'b0 : ref_is_store(op);
      base = (ind && k == 1) ? ptr : alu;
      ea   = (ind && k == 0) ? (alu & 16'hFFFE) : ref_addr(op, base);
      be   = (ind && k == 0) ? 2'b11 : ref_be(op, base);
      for (int c = 0; c <= wt; c++) begin
        @(negedge clk);
        garbage_inputs();
        flush = (fk == k && c == 0);
        if (flush) killed = 1'b1;
        mem_resp  = (c == wt);
        word      = rd(ea & 16'hFFFE);
        mem_rdata = mem_resp ? word : 16'($urandom);
        #1;
        chk_req("busy", st, ea, be, ref_wdata(op, sr));
        last = (c == wt) && ((k == nacc - 1) || (killed && ind && k == 0));
        check("busy_stall", 32'(stall), 32'(!last));
        if (stall) stall_cnt++;
      end
      if (ind && k == 0) begin
        ptr = word;
        if (killed) break;
      end else begin
        exp_ld = ref_load(op, base, word);
        if (st) model_store(op, base, sr);
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    check("post_rd", 32'(mem_read), 32'(0));
    check("post_wr", 32'(mem_write), 32'(0));
    check("post_stall", 32'(stall), 32'(0));
    check("mem_wb_valid", 32'(wb_valid), 32'(!killed));
    if (!killed) begin
      check("mem_wb_ipacket", 32'(wb_ipacket), 32'(pk));
      check("mem_wb_alu", 32'(wb_alu), 32'(alu));
      check("mem_wb_br", 32'(wb_br_addr), 32'(br));
      check("mem_wb_mem", 32'(wb_mem), 32'(ref_is_store(op) ? 16'h0 : exp_ld));
    end
  endtask

  initial begin
    lc3b_opcode  op;
    logic [15:0] a;
    int          r, fm;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_ipacket = '0;
    alu_in     = 16'h0;
    sr_in      = 16'h0;
    br_addr_in = 16'h0;
    flush      = 1'b0;
    mem_rdata  = 16'h0;
    mem_resp   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem_model[16'h3000 + 16'(2 * i)] = 16'h3000 + 16'($urandom_range(0, 31));
    end

    repeat (2) @(negedge clk);
    #1;
    check("rst_rd", 32'(mem_read), 32'(0));
    check("rst_wr", 32'(mem_write), 32'(0));
    check("rst_be", 32'(mem_byte_enable), 32'(0));
    check("rst_stall", 32'(stall), 32'(0));
    check("rst_wb_valid", 32'(wb_valid), 32'(0));
    check("rst_wb_alu", 32'(wb_alu), 32'(0));
    check("rst_wb_mem", 32'(wb_mem), 32'(0));
    check("rst_wb_br", 32'(wb_br_addr), 32'(0));
    check("rst_wb_ipacket", 32'(wb_ipacket), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_op(OP_ADD, 16'h1234, 16'h0001, 16'h0200, 0, 0, 0);
    mem_model[16'h3000] = 16'hBEEF;
    run_op(OP_LDR, 16'h3001, 16'h0000, 16'h0300, 0, 3, 0);
    check("ldr_stall_cycles", 32'(stall_cnt), 32'(4));
    mem_model[16'h3000] = 16'h80FF;
    run_op(OP_LDB, 16'h3001, 16'h0000, 16'h0301, 0, 1, 0);
    run_op(OP_STB, 16'h4000, 16'h12AB, 16'h0302, 0, 2, 0);
    mem_model[16'h5000] = 16'h6002;
    run_op(OP_STI, 16'h5000, 16'h7777, 16'h0303, 0, 1, 2);
    check("sti_mem_model", 32'(rd(16'h6002)), 32'(16'h7777));
    run_op(OP_STI, 16'h5000, 16'h1111, 16'h0304, 2, 2, 1);
    run_op(OP_LDI, 16'h5001, 16'h0000, 16'h0305, 0, 0, 0);
    run_op(OP_LDR, 16'h3002, 16'h0000, 16'h0306, 1, 0, 0);
    run_op(OP_STR, 16'h3005, 16'hCAFE, 16'h0307, 3, 0, 0);

    for (int n = 0; n < 150; n++) begin
      op = lc3b_opcode'(4'($urandom));
      a  = ref_is_mem(op) ? 16'h3000 + 16'($urandom_range(0, 31)) : 16'($urandom);
      r  = int'($urandom_range(0, 9));
      fm = (r < 3) ? r + 1 : 0;
      run_op(op, a, 16'($urandom), 16'($urandom), fm,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Asynchronous reset in the middle of an access.
    @(negedge clk);
    in_valid   = 1'b1;
    in_ipacket = '{opcode: OP_LDR, dr: 3'd1, ld_reg: 1'b1, ld_cc: 1'b1, pc: 16'h0400};
    alu_in     = 16'h3002;
    @(negedge clk);
    idle_inputs();
    #1;
    check("pre_rst_rd", 32'(mem_read), 32'(1));
    check("pre_rst_stall", 32'(stall), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rd", 32'(mem_read), 32'(0));
    check("arst_stall", 32'(stall), 32'(0));
    check("arst_wb_valid", 32'(wb_valid), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_resp  = 1'b1;
    mem_rdata = 16'h1357;
    #1;
    check("stray_rd", 32'(mem_read), 32'(0));
    check("stray_wr", 32'(mem_write), 32'(0));
    check("stray_stall", 32'(stall), 32'(0));
    @(negedge clk);
    mem_resp = 1'b0;
    #1;
    check("stray_wb_valid", 32'(wb_valid), 32'(0));
    check("stray_rd2", 32'(mem_read), 32'(0));

    // Reset also clears a live writeback packet immediately.
    run_op(OP_ADD, 16'h55AA, 16'h0000, 16'h0500, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_wb_valid2", 32'(wb_valid), 32'(0));
    check("arst_wb_alu", 32'(wb_alu), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
